// File: rtl/func_equiv_checker.sv
// -----------------------------------------------------------------------------
// func_equiv_checker
// Sweeps every minterm of two N-input Boolean functions, given as truth
// tables, and reports whether they are equivalent. One minterm is compared per
// clock. The sweep either covers all 2^N minterms or stops at the first
// mismatch.
//
// Ports
//   i_clk          : clock; all state updates on the rising edge
//   i_rst          : synchronous active-high reset
//   i_start        : begin a sweep (accepted only in IDLE)
//   i_mode         : 0 = full sweep, 1 = stop at first mismatch
//   i_f_tt, i_g_tt : truth tables, bit i = function value at minterm i
//   o_busy         : sweep in progress (SWEEP or DONE_ST)
//   o_done         : one-cycle completion pulse
//   o_equiv        : last sweep found no mismatches
//   o_mismatch_cnt : number of mismatching minterms (N+1 bits, holds 2^N)
//   o_first_valid  : o_first_idx holds a valid index
//   o_first_idx    : lowest mismatching minterm index
//   o_minterm      : minterm index currently being compared
// -----------------------------------------------------------------------------
module func_equiv_checker #(
  parameter int N = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_mode,
  input  logic [2**N-1:0] i_f_tt,
  input  logic [2**N-1:0] i_g_tt,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_equiv,
  output logic [N:0]      o_mismatch_cnt,
  output logic            o_first_valid,
  output logic [N-1:0]    o_first_idx,
  output logic [N-1:0]    o_minterm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  localparam logic [N-1:0]    LAST_MT  = {N{1'b1}};
  localparam logic [N-1:0]    MT_ZERO  = {N{1'b0}};
  localparam logic [N-1:0]    MT_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]      CNT_ZERO = {(N+1){1'b0}};
  localparam logic [N:0]      CNT_ONE  = {{N{1'b0}}, 1'b1};
  localparam logic [2**N-1:0] TT_ZERO  = {(2**N){1'b0}};

  state_t            r_state, w_state;
  logic [2**N-1:0]   r_f_tt, w_f_tt;
  logic [2**N-1:0]   r_g_tt, w_g_tt;
  logic              r_mode, w_mode;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_equiv, w_equiv;
  logic [N:0]        r_cnt, w_cnt;
  logic              r_first_valid, w_first_valid;
  logic [N-1:0]      r_first_idx, w_first_idx;
  logic [N-1:0]      r_minterm, w_minterm;
  logic              w_mis;

  // Compare the captured tables at the current minterm.
  assign w_mis = r_f_tt[r_minterm] ^ r_g_tt[r_minterm];

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    w_state       = r_state;
    w_f_tt        = r_f_tt;
    w_g_tt        = r_g_tt;
    w_mode        = r_mode;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_equiv       = r_equiv;
    w_cnt         = r_cnt;
    w_first_valid = r_first_valid;
    w_first_idx   = r_first_idx;
    w_minterm     = r_minterm;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_f_tt        = i_f_tt;
          w_g_tt        = i_g_tt;
          w_mode        = i_mode;
          w_cnt         = CNT_ZERO;
          w_first_valid = 1'b0;
          w_first_idx   = MT_ZERO;
          w_equiv       = 1'b0;
          w_minterm     = MT_ZERO;
          w_busy        = 1'b1;
          w_state       = SWEEP;
        end else begin
          w_busy = 1'b0;
        end
      end
      SWEEP: begin
        if (w_mis) begin
          w_cnt = r_cnt + CNT_ONE;
          // Only the first mismatch of the sweep records its index.
          if (!r_first_valid) begin
            w_first_valid = 1'b1;
            w_first_idx   = r_minterm;
          end else begin
            w_first_valid = r_first_valid;
          end
        end else begin
          w_cnt = r_cnt;
        end
        // Stop at the last minterm so the index never wraps.
        if ((r_minterm == LAST_MT) || (r_mode && w_mis)) begin
          w_state = DONE_ST;
        end else begin
          w_minterm = r_minterm + MT_ONE;
        end
      end
      DONE_ST: begin
        w_done  = 1'b1;
        w_equiv = (r_cnt == CNT_ZERO);
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: begin
        w_busy  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_f_tt        <= TT_ZERO;
      r_g_tt        <= TT_ZERO;
      r_mode        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_equiv       <= 1'b0;
      r_cnt         <= CNT_ZERO;
      r_first_valid <= 1'b0;
      r_first_idx   <= MT_ZERO;
      r_minterm     <= MT_ZERO;
    end else begin
      r_state       <= w_state;
      r_f_tt        <= w_f_tt;
      r_g_tt        <= w_g_tt;
      r_mode        <= w_mode;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_equiv       <= w_equiv;
      r_cnt         <= w_cnt;
      r_first_valid <= w_first_valid;
      r_first_idx   <= w_first_idx;
      r_minterm     <= w_minterm;
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_equiv        = r_equiv;
  assign o_mismatch_cnt = r_cnt;
  assign o_first_valid  = r_first_valid;
  assign o_first_idx    = r_first_idx;
  assign o_minterm      = r_minterm;

endmodule

// File: tb/tb_func_equiv_checker.sv
module tb_func_equiv_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] f_tt;
  logic [7:0] g_tt;
  logic       o_busy;
  logic       o_done;
  logic       o_equiv;
  logic [3:0] o_mismatch_cnt;
  logic       o_first_valid;
  logic [2:0] o_first_idx;
  logic [2:0] o_minterm;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic       eq;
    logic [3:0] cnt;
    logic       fv;
    logic [2:0] fidx;
    logic [2:0] mt;
  } exp_t;

  exp_t sb[$];

  func_equiv_checker #(.N(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_mode        (mode),
    .i_f_tt        (f_tt),
    .i_g_tt        (g_tt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_equiv       (o_equiv),
    .o_mismatch_cnt(o_mismatch_cnt),
    .o_first_valid (o_first_valid),
    .o_first_idx   (o_first_idx),
    .o_minterm     (o_minterm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one sweep; glitch >= 0 changes inputs and pulses START after that cycle.
  task automatic run_sweep(input string tag, input logic [7:0] f, input logic [7:0] g,
                           input logic m, input int cyc, input logic eq,
                           input logic [3:0] cnt, input logic fv, input logic [2:0] fidx,
                           input logic [2:0] mt, input int glitch);
    exp_t e;
    int   c;
    bit   got;
    int   extra_done;
    e.cyc = cyc; e.eq = eq; e.cnt = cnt; e.fv = fv; e.fidx = fidx; e.mt = mt;
    sb.push_back(e);
    @(negedge clk);
    f_tt = f; g_tt = g; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, 32'(o_busy), 32'd1);
    chk({tag, ".cnt_start"}, 32'(o_mismatch_cnt), 32'd0);
    chk({tag, ".mt_start"}, 32'(o_minterm), 32'd0);
    got = 1'b0;
    c = 0;
    while (!got && c < 40) begin
      if (c == glitch) begin
        g_tt  = ~f;
        mode  = ~m;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      if (o_done) got = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".done_cycle"}, 32'(c), 32'(e.cyc));
    chk({tag, ".equiv"}, 32'(o_equiv), 32'(e.eq));
    chk({tag, ".cnt"}, 32'(o_mismatch_cnt), 32'(e.cnt));
    chk({tag, ".first_valid"}, 32'(o_first_valid), 32'(e.fv));
    chk({tag, ".first_idx"}, 32'(o_first_idx), 32'(e.fidx));
    chk({tag, ".minterm"}, 32'(o_minterm), 32'(e.mt));
    chk({tag, ".busy_done"}, 32'(o_busy), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (o_done) extra_done++;
    end
    chk({tag, ".one_pulse"}, 32'(extra_done), 32'd0);
    chk({tag, ".hold_equiv"}, 32'(o_equiv), 32'(e.eq));
    chk({tag, ".hold_cnt"}, 32'(o_mismatch_cnt), 32'(e.cnt));
    chk({tag, ".hold_idx"}, 32'(o_first_idx), 32'(e.fidx));
    chk({tag, ".hold_mt"}, 32'(o_minterm), 32'(e.mt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".done"}, 32'(o_done), 32'd0);
    chk({tag, ".equiv"}, 32'(o_equiv), 32'd0);
    chk({tag, ".cnt"}, 32'(o_mismatch_cnt), 32'd0);
    chk({tag, ".first_valid"}, 32'(o_first_valid), 32'd0);
    chk({tag, ".first_idx"}, 32'(o_first_idx), 32'd0);
    chk({tag, ".minterm"}, 32'(o_minterm), 32'd0);
  endtask

  initial begin
    int rst_done;
    rst = 1'b1; start = 1'b1; mode = 1'b0; f_tt = 8'hFF; g_tt = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    start = 1'b0;
    rst = 1'b0;

    //         tag       F      G      M     cyc eq    cnt    fv    idx   mt    glitch
    run_sweep("equiv",   8'hE0, 8'hE0, 1'b0, 9, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7, -1);
    run_sweep("single",  8'hE0, 8'hC0, 1'b0, 9, 1'b0, 4'd1, 1'b1, 3'd5, 3'd7, -1);
    run_sweep("stop1st", 8'hE0, 8'h00, 1'b1, 7, 1'b0, 4'd1, 1'b1, 3'd5, 3'd5, -1);
    run_sweep("allmis",  8'hFF, 8'h00, 1'b0, 9, 1'b0, 4'd8, 1'b1, 3'd0, 3'd7, -1);
    run_sweep("stop_k0", 8'hFF, 8'h00, 1'b1, 2, 1'b0, 4'd1, 1'b1, 3'd0, 3'd0, -1);
    run_sweep("stop_eq", 8'h5A, 8'h5A, 1'b1, 9, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7, -1);
    run_sweep("lastmis", 8'h5A, 8'hDA, 1'b0, 9, 1'b0, 4'd1, 1'b1, 3'd7, 3'd7, -1);
    run_sweep("glitch",  8'hE0, 8'hE0, 1'b0, 9, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7, 3);

    // Reset in the middle of a sweep: no DONE, everything cleared.
    @(negedge clk);
    f_tt = 8'hE0; g_tt = 8'hE0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst_done = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (o_done) rst_done++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_done) rst_done++;
    end
    chk("midrst.no_done", 32'(rst_done), 32'd0);
    chk_all_zero("midrst.idle");
    run_sweep("after_rst", 8'hE0, 8'hC0, 1'b0, 9, 1'b0, 4'd1, 1'b1, 3'd5, 3'd7, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/func_equiv_checker.md
FUNC_EQUIV_CHECKER -- requirements
Module: func_equiv_checker

Interface
REQ-001 The block SHALL provide parameter N, default 3, giving the number of Boolean inputs of each function (legal range 1..8).
REQ-002 The block SHALL provide port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port RST, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL provide port START, input, 1, request to begin one equivalence sweep.
REQ-005 The block SHALL provide port MODE, input, 1, sweep mode: 0 means full sweep, 1 means stop at the first mismatch.
REQ-006 The block SHALL provide port F_TT, input, 2^N, truth table of function F; bit i = F(minterm i), inputs packed MSB-first, e.g. i = {A,B,C}.
REQ-007 The block SHALL provide port G_TT, input, 2^N, truth table of function G (e.g. the minimised form), same packing as F_TT.
REQ-008 The block SHALL provide port BUSY, output, 1, high while a sweep is in progress.
REQ-009 The block SHALL provide port DONE, output, 1, a one-cycle pulse when a sweep completes.
REQ-010 The block SHALL provide port EQUIV, output, 1, set when the last sweep found zero mismatches.
REQ-011 The block SHALL provide port MISMATCH_CNT, output, N+1, the number of mismatching minterms found.
REQ-012 The block SHALL provide port FIRST_VALID, output, 1, set once FIRST_IDX holds a valid index.
REQ-013 The block SHALL provide port FIRST_IDX, output, N, the lowest minterm index at which F differs from G.
REQ-014 The block SHALL provide port MINTERM, output, N, the minterm index currently being compared.

Function
REQ-015 The FSM SHALL have three states: IDLE, SWEEP and DONE_ST.
REQ-016 In IDLE with START=1, the block SHALL capture F_TT, G_TT and MODE into internal registers.
REQ-017 On that same start cycle it SHALL clear MISMATCH_CNT, FIRST_VALID, FIRST_IDX, EQUIV and MINTERM to 0 and move to SWEEP.
REQ-018 START SHALL be ignored in SWEEP and DONE_ST.
REQ-019 Changes on F_TT, G_TT or MODE after capture SHALL NOT affect the sweep in progress.
REQ-020 In SWEEP the block SHALL compare exactly one minterm per cycle, at index MINTERM, using the captured tables.
REQ-021 On a mismatch, MISMATCH_CNT SHALL increment by 1.
REQ-022 On the first mismatch of a sweep, FIRST_IDX SHALL take the current MINTERM and FIRST_VALID SHALL go to 1.
REQ-023 FIRST_IDX SHALL be loaded at most once per sweep.
REQ-024 From SWEEP the FSM SHALL go to DONE_ST when MINTERM = 2^N-1, or when captured MODE=1 and the current minterm mismatches; otherwise MINTERM SHALL increment.
REQ-025 MINTERM SHALL never wrap past 2^N-1.
REQ-026 MISMATCH_CNT SHALL be N+1 bits wide so it can hold 2^N without overflow.
REQ-027 In DONE_ST, DONE SHALL be 1 for exactly one cycle, EQUIV SHALL be set to (MISMATCH_CNT == 0), and the FSM SHALL return to IDLE.
REQ-028 BUSY SHALL be 1 in SWEEP and DONE_ST and 0 in IDLE.
REQ-029 Latency: with START accepted at cycle 0, a full sweep SHALL assert DONE at cycle 2^N+1.
REQ-030 For MODE=1 with first mismatch at index k, DONE SHALL assert at cycle k+2.
REQ-031 EQUIV, MISMATCH_CNT, FIRST_IDX, FIRST_VALID and MINTERM SHALL hold their values after DONE until the next accepted START or RST.
REQ-032 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-033 When RST=1 at a rising edge, the FSM SHALL go to IDLE and every output (BUSY, DONE, EQUIV, MISMATCH_CNT, FIRST_VALID, FIRST_IDX, MINTERM) SHALL be 0.
REQ-034 RST SHALL take priority over START.
REQ-035 A sweep in progress at reset SHALL be abandoned with no DONE pulse.
REQ-036 After RST deasserts, a START SHALL be accepted in the first IDLE cycle.

Verification
REQ-037 Equivalent pair: N=3, F_TT=8'hE0 (AB+AB'C), G_TT=8'hE0 (A(B+C)), MODE=0 -> DONE at cycle 9, EQUIV=1, MISMATCH_CNT=0, FIRST_VALID=0.
REQ-038 Single mismatch: F_TT=8'hE0, G_TT=8'hC0, MODE=0 -> DONE at cycle 9, EQUIV=0, MISMATCH_CNT=1, FIRST_IDX=5, FIRST_VALID=1.
REQ-039 Stop-first: F_TT=8'hE0, G_TT=8'h00, MODE=1 -> DONE at cycle 7, MISMATCH_CNT=1, FIRST_IDX=5, MINTERM=5.
REQ-040 Full mismatch count: F_TT=8'hFF, G_TT=8'h00, MODE=0 -> MISMATCH_CNT=8 (no overflow), FIRST_IDX=0.
REQ-041 Input changes and START during a sweep: F_TT=8'hE0, G_TT=8'hE0; change G_TT to 8'h00 and pulse START at cycle 3 -> result unchanged (EQUIV=1, DONE at cycle 9, one DONE pulse only).
REQ-042 Reset mid-sweep: assert RST at cycle 4 -> no DONE pulse, all outputs 0, and a new START one cycle after RST deasserts completes normally.
